// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBUS types and helpers used by the SRAM responder and other
// bus agents (arbiter, cache).
package cbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MLEN1  = 3'd0,
    MLEN2  = 3'd1,
    MLEN4  = 3'd2,
    MLEN8  = 3'd3,
    MLEN16 = 3'd4
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    mlen_t       len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Undefined len encodings degrade to a single beat.
  function automatic logic [4:0] mlen_to_beats(input mlen_t len);
    case (len)
      MLEN1:   return 5'd1;
      MLEN2:   return 5'd2;
      MLEN4:   return 5'd4;
      MLEN8:   return 5'd8;
      MLEN16:  return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/cbus_sram_responder_sram_bank.sv
// MEM_WORDS x 32 storage with asynchronous read and per-byte write enables.
// Contents are deliberately not reset.
module sram_bank #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/cbus_sram_responder.sv
// CBUS burst responder backed by a single SRAM bank: accepts one request,
// waits LATENCY cycles, then streams one beat per cycle with address wrap.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t        state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [4:0]    count_q, count_d;
  logic [4:0]    beat_q, beat_d;
  logic [3:0]    lat_q, lat_d;

  logic [AW-1:0] word_addr;
  logic [31:0]   rdata;
  logic          mem_we;
  logic          last_beat;

  // Only the word-index bits of the byte address select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{creq.addr[1:0], creq.addr[31:2+AW]};

  // Natural AW-bit overflow gives the wrap at the end of the array.
  assign word_addr = idx_q + AW'(beat_q);
  assign last_beat = (beat_q == count_q - 5'd1);

  sram_bank #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_bank (
    .clk   (clk),
    .we    (mem_we),
    .be    (creq.strobe),
    .addr  (word_addr),
    .wdata (creq.data),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    count_d    = count_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    mem_we     = 1'b0;
    cresp      = '0;

    case (state_q)
      IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          idx_d      = creq.addr[2 +: AW];
          count_d    = mlen_to_beats(creq.len);
          beat_d     = '0;
          lat_d      = '0;
          state_d    = (LATENCY == 0) ? BURST : WAIT;
        end
      end

      WAIT: begin
        if (!creq.valid) begin
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          state_d = BURST;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      BURST: begin
        // A dropped valid mid-burst is a protocol violation: abandon silently.
        if (!creq.valid) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          cresp.ready = 1'b1;
          cresp.last  = last_beat;
          cresp.data  = is_write_q ? 32'd0 : rdata;
          mem_we      = is_write_q & resetn;
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder (MEM_WORDS=4096, LATENCY=2).
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  logic       clk;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd [16];

  cbus_sram_responder #(
    .MEM_WORDS (4096),
    .LATENCY   (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .creq   (creq),
    .cresp  (cresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge; returns just after the edge that
  // follows the last beat (or after a 40-cycle budget).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input mlen_t len,
                         input logic [3:0] strb, input logic [31:0] wbase,
                         output int nbeats, output int first_cyc,
                         output logic [15:0] last_mask, output logic dirty);
    int b;
    logic done;
    b = 0; done = 1'b0; first_cyc = -1; last_mask = '0; dirty = 1'b0;
    for (int i = 0; i < 16; i++) rd[i] = '0;
    creq.valid = 1'b1; creq.is_write = wr; creq.addr = addr; creq.len = len;
    creq.strobe = strb; creq.data = wbase;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cresp.ready) begin
        if (first_cyc < 0) first_cyc = c;
        if (b < 16) begin
          rd[b] = cresp.data;
          last_mask[b] = cresp.last;
        end
        b++;
        if (cresp.last) done = 1'b1;
      end else if (cresp.last !== 1'b0 || cresp.data !== 32'd0) begin
        dirty = 1'b1;
      end
      @(posedge clk); #1;
      // Scramble latched fields to show they are ignored after acceptance.
      if (c == 0) begin
        creq.addr = 32'hFFFF_FFFC; creq.len = MLEN16; creq.is_write = ~wr;
      end
      creq.data = wbase + 32'(b);
    end
    creq.valid = 1'b0;
    nbeats = b;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    creq = '0;
    creq.valid = 1'b1; creq.len = MLEN4;
    #2;
    total++; if (cresp.ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cresp.ready); end
    total++; if (cresp.last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", cresp.last); end
    total++; if (cresp.data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", cresp.data); end
    @(posedge clk); @(posedge clk); #1;
    creq.valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (cresp.ready !== 1'b0) begin bad++; $display("FAIL post_reset_ready: got %b want 0", cresp.ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int nb, fc; logic [15:0] lm; logic dt;
    run_txn(1'b1, 32'h100, MLEN1, 4'hF, 32'hDEADBEEF, nb, fc, lm, dt);
    total++; if (nb !== 1) begin bad++; $display("FAIL single_wr_beats: got %0d want 1", nb); end
    run_txn(1'b0, 32'h100, MLEN1, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (fc !== 3) begin bad++; $display("FAIL single_rd_latency: got %0d want 3", fc); end
    total++; if (nb !== 1) begin bad++; $display("FAIL single_rd_beats: got %0d want 1", nb); end
    total++; if (lm !== 16'h0001) begin bad++; $display("FAIL single_rd_last: got %h want 0001", lm); end
    total++; if (rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rd_data: got %h want deadbeef", rd[0]); end
    total++; if (dt !== 1'b0) begin bad++; $display("FAIL single_rd_idle_outputs: got %b want 0", dt); end
  endtask

  task automatic test_burst16();
    int nb, fc; logic [15:0] lm; logic dt;
    run_txn(1'b1, 32'h200, MLEN16, 4'hF, 32'h0, nb, fc, lm, dt);
    total++; if (nb !== 16) begin bad++; $display("FAIL b16_wr_beats: got %0d want 16", nb); end
    total++; if (lm !== 16'h8000) begin bad++; $display("FAIL b16_wr_last: got %h want 8000", lm); end
    total++; if (dt !== 1'b0) begin bad++; $display("FAIL b16_wr_idle_outputs: got %b want 0", dt); end
    run_txn(1'b0, 32'h200, MLEN16, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (nb !== 16) begin bad++; $display("FAIL b16_rd_beats: got %0d want 16", nb); end
    total++; if (lm !== 16'h8000) begin bad++; $display("FAIL b16_rd_last: got %h want 8000", lm); end
    total++; if (fc !== 3) begin bad++; $display("FAIL b16_rd_latency: got %0d want 3", fc); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd[i] !== 32'(i)) begin bad++; $display("FAIL b16_rd_data[%0d]: got %h want %h", i, rd[i], 32'(i)); end
    end
  endtask

  task automatic test_strobe();
    int nb, fc; logic [15:0] lm; logic dt;
    run_txn(1'b1, 32'h300, MLEN1, 4'hF, 32'hAAAAAAAA, nb, fc, lm, dt);
    run_txn(1'b1, 32'h300, MLEN1, 4'b0101, 32'h11223344, nb, fc, lm, dt);
    run_txn(1'b0, 32'h300, MLEN1, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (rd[0] !== 32'hAA22AA44) begin bad++; $display("FAIL strobe_merge: got %h want aa22aa44", rd[0]); end
  endtask

  task automatic test_wrap();
    int nb, fc; logic [15:0] lm; logic dt;
    run_txn(1'b1, 32'h3FF8, MLEN4, 4'hF, 32'h77000000, nb, fc, lm, dt);
    run_txn(1'b0, 32'h3FF8, MLEN4, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (nb !== 4) begin bad++; $display("FAIL wrap_beats: got %0d want 4", nb); end
    total++; if (lm !== 16'h0008) begin bad++; $display("FAIL wrap_last: got %h want 0008", lm); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd[i] !== 32'h77000000 + 32'(i)) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd[i], 32'h77000000 + 32'(i)); end
    end
    run_txn(1'b0, 32'h0, MLEN2, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (rd[0] !== 32'h77000002) begin bad++; $display("FAIL wrap_word0: got %h want 77000002", rd[0]); end
    total++; if (rd[1] !== 32'h77000003) begin bad++; $display("FAIL wrap_word1: got %h want 77000003", rd[1]); end
  endtask

  task automatic test_reset_mid_burst();
    int nb, fc; logic [15:0] lm; logic dt;
    int b;
    logic hit;
    logic [31:0] exp;
    run_txn(1'b1, 32'h400, MLEN8, 4'hF, 32'hC0DE0000, nb, fc, lm, dt);
    total++; if (nb !== 8) begin bad++; $display("FAIL rst_preload_beats: got %0d want 8", nb); end
    b = 0; hit = 1'b0;
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = 32'h400; creq.len = MLEN8;
    creq.strobe = 4'hF; creq.data = 32'h5A5A0000;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (cresp.ready) begin
        if (b == 3) begin
          resetn = 1'b0;
          #1;
          hit = 1'b1;
          total++;
          if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 32'd0) begin
            bad++; $display("FAIL rst_mid_outputs: got ready=%b last=%b data=%h want 0/0/0", cresp.ready, cresp.last, cresp.data);
          end
        end else begin
          b++;
        end
      end
      if (!hit) begin
        @(posedge clk); #1;
        creq.data = 32'h5A5A0000 + 32'(b);
      end
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rst_mid_reached_beat3: got %b want 1", hit); end
    creq.valid = 1'b0;
    @(posedge clk); #1;
    total++; if (cresp.ready !== 1'b0) begin bad++; $display("FAIL rst_mid_hold_ready: got %b want 0", cresp.ready); end
    resetn = 1'b1;
    run_txn(1'b0, 32'h400, MLEN8, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (nb !== 8) begin bad++; $display("FAIL rst_after_beats: got %0d want 8", nb); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 3) ? 32'h5A5A0000 + 32'(i) : 32'hC0DE0000 + 32'(i);
      total++;
      if (rd[i] !== exp) begin bad++; $display("FAIL rst_after_word[%0d]: got %h want %h", i, rd[i], exp); end
    end
  endtask

  task automatic test_back_to_back();
    int nb, fc; logic [15:0] lm; logic dt;
    run_txn(1'b1, 32'h500, MLEN2, 4'hF, 32'h0B0B0000, nb, fc, lm, dt);
    run_txn(1'b0, 32'h500, MLEN2, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (fc !== 3) begin bad++; $display("FAIL b2b_first_latency: got %0d want 3", fc); end
    total++; if (nb !== 2) begin bad++; $display("FAIL b2b_first_beats: got %0d want 2", nb); end
    total++; if (rd[0] !== 32'h0B0B0000) begin bad++; $display("FAIL b2b_first_data: got %h want 0b0b0000", rd[0]); end
    run_txn(1'b0, 32'h504, MLEN1, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (fc !== 3) begin bad++; $display("FAIL b2b_second_latency: got %0d want 3", fc); end
    total++; if (rd[0] !== 32'h0B0B0001) begin bad++; $display("FAIL b2b_second_data: got %h want 0b0b0001", rd[0]); end
  endtask

  task automatic test_abort_wait();
    int nb, fc; logic [15:0] lm; logic dt;
    logic any_ready;
    run_txn(1'b1, 32'h800, MLEN1, 4'hF, 32'h12345678, nb, fc, lm, dt);
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = 32'h800; creq.len = MLEN1;
    creq.strobe = 4'hF; creq.data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    creq.valid = 1'b0;
    any_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cresp.ready) any_ready = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (any_ready !== 1'b0) begin bad++; $display("FAIL abort_no_beats: got %b want 0", any_ready); end
    run_txn(1'b0, 32'h800, MLEN1, 4'h0, 32'h0, nb, fc, lm, dt);
    total++; if (fc !== 3) begin bad++; $display("FAIL abort_next_latency: got %0d want 3", fc); end
    total++; if (rd[0] !== 32'h12345678) begin bad++; $display("FAIL abort_no_write: got %h want 12345678", rd[0]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst16();
    test_strobe();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    test_abort_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbus_sram_responder.md
CBUS_SRAM_RESPONDER -- requirements
Module: cbus_sram_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, number of 32-bit words backing the responder (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, idle cycles between request acceptance and first beat (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port creq  input  cbus_req_t  fields used: valid, is_write, addr, len, strobe, data.
REQ-006 SHALL have port cresp  output  cbus_resp_t  fields driven: ready, last, data.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, BURST.
REQ-008 In IDLE with creq.valid=1, SHALL latch is_write, word index = addr[2 +: log2(MEM_WORDS)], beat count = len decoded (MLEN1/2/4/8/16 -> 1/2/4/8/16); next state WAIT, or BURST directly if LATENCY=0.
REQ-009 WAIT SHALL count LATENCY cycles from acceptance, then enter BURST; cresp.ready=0 throughout.
REQ-010 In BURST, cresp.ready SHALL be 1 every cycle, one beat per cycle, no stalls.
REQ-011 Beat k SHALL address word (latched index + k) modulo MEM_WORDS; address wraps at array end.
REQ-012 Read beat: cresp.data SHALL equal the current word in the same cycle ready=1.
REQ-013 Write beat: each byte i with creq.strobe[i]=1 SHALL take creq.data byte i at the clock edge ending that beat; other bytes unchanged; cresp.data=0.
REQ-014 cresp.last SHALL be 1 only on the final beat (beat = count-1); single-beat requests assert ready and last together.
REQ-015 After the last beat the FSM SHALL return to IDLE; a new request is accepted no earlier than the following cycle (minimum one dead cycle between transactions).
REQ-016 Request fields other than data/strobe SHALL be ignored after acceptance; only the latched values are used.
REQ-017 If creq.valid drops in WAIT or BURST (protocol violation), SHALL abort to IDLE next cycle, no further writes, ready=0.
REQ-018 Reads return full words regardless of size; sub-word selection is the initiator's job.
REQ-019 Whenever ready=0, cresp.data and cresp.last SHALL be 0.

Reset
REQ-020 resetn=0 SHALL immediately force state IDLE, beat counter 0, latency counter 0, cresp.ready=0, cresp.last=0, cresp.data=0.
REQ-021 Reset mid-burst SHALL abandon the transaction; no write occurs at or after reset assertion.
REQ-022 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-023 cbus_req_t, cbus_resp_t, mlen_t stay in the shared common package; a len-to-beat-count function SHALL be added there for reuse by arbiter/cache.
REQ-024 FSM state enum SHALL be local to the module.
REQ-025 One sub-module, sram_bank (MEM_WORDS x 32, async read, per-byte write enable), SHALL hold the array.
REQ-026 Implementation target 150-300 lines RTL total.

Verification
REQ-027 Reset then MLEN1 read, addr 0x100, mem[0x40]=0xDEADBEEF, LATENCY=2 -> ready=1,last=1,data=0xDEADBEEF on 3rd cycle after acceptance, exactly one beat.
REQ-028 MLEN16 write at 0x200, data 0..15, strobe 0xF; then MLEN16 read -> 16 consecutive ready beats, data 0..15, last only on beat 16.
REQ-029 MLEN1 write 0x11223344 strobe 0b0101 over word 0xAAAAAAAA -> readback 0xAA22AA44.
REQ-030 MLEN4 read starting word MEM_WORDS-2 -> beats return words MEM_WORDS-2, MEM_WORDS-1, 0, 1.
REQ-031 resetn low during beat 3 of MLEN8 write -> outputs 0 same cycle, words 3..7 unchanged, next request served normally.
REQ-032 Back-to-back requests with valid held -> second transaction starts one dead cycle after first last; valid dropped mid-WAIT -> IDLE, no beats.
